pc_seq_unit: RTL and testbench

Parametrised program-counter sequencer for the fetch stage. It holds the PC register and selects the next PC from six modes: sequential, branch, jump, jump-register, call and return. It adds an exception redirect and a circular return-address stack (RAS) that predicts return targets. It sits between the control decoder (mode select, stall, exception) and the instruction memory address port.

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/pc_seq_unit_ras_stack.sv | 56 +++++
 rtl/pc_seq_unit.sv | 101 ++++++++++
 tb/tb_pc_seq_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings and default vectors for the PC sequencer and the control decoder.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        PC_SEQ  = 3'd0,
        PC_BR   = 3'd1,
        PC_J    = 3'd2,
        PC_JR   = 3'd3,
        PC_CALL = 3'd4,
        PC_RET  = 3'd5
    } pc_sel_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

endpackage

// File: rtl/pc_seq_unit_ras_stack.sv
// Circular return-address stack: a push overwrites the oldest entry when full, and the count saturates.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           push,
    input  logic                           pop,
    input  logic [XLEN-1:0]                push_data,
    output logic [XLEN-1:0]                top,
    output logic [$clog2(RAS_DEPTH):0]     count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [XLEN-1:0]  mem_d [RAS_DEPTH];

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_W'(1);
            count_d      = (count_q == FULL) ? count_q : count_q + CNT_W'(1);
        end else if (pop && count_q != '0) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Entry contents are meaningless after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top   = mem_q[ptr_q - PTR_W'(1)];
    assign count = count_q;

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program counter: next-PC mux, exception redirect and return prediction via the RAS.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC),
    parameter int              RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           stall,
    input  logic                           exc,
    input  logic [2:0]                     pc_sel,
    input  logic [31:0]                    inst,
    input  logic [XLEN-1:0]                a,
    output logic [XLEN-1:0]                pc,
    output logic [XLEN-1:0]                ra,
    output logic [XLEN-1:0]                epc,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ret_mismatch
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            ret_mismatch_q, ret_mismatch_d;

    logic [XLEN-1:0] imm_ext, br_tgt, j_tgt, a_tgt, ras_top;
    logic            ras_push, ras_pop;
    logic            unused_bits;

    assign ra      = pc_q + XLEN'(4);
    assign imm_ext = {{(XLEN-16){inst[15]}}, inst[15:0]};
    assign br_tgt  = pc_q + (imm_ext << 2);
    assign j_tgt   = {pc_q[XLEN-1:28], inst[25:0], 2'b00};
    assign a_tgt   = {a[XLEN-1:2], 2'b00};
    assign unused_bits = ^{inst[31:26], a[1:0]};

    // An exception overrides a stall and leaves the RAS untouched; a stall also clears the mismatch pulse.
    always_comb begin
        pc_d           = pc_q;
        epc_d          = epc_q;
        ret_mismatch_d = 1'b0;
        ras_push       = 1'b0;
        ras_pop        = 1'b0;
        if (exc) begin
            pc_d  = EXC_VEC;
            epc_d = pc_q;
        end else if (!stall) begin
            case (pc_sel)
                PC_BR:   pc_d = br_tgt;
                PC_J:    pc_d = j_tgt;
                PC_JR:   pc_d = a_tgt;
                PC_CALL: begin
                    pc_d     = j_tgt;
                    ras_push = 1'b1;
                end
                PC_RET: begin
                    if (ras_count != '0) begin
                        pc_d           = ras_top;
                        ras_pop        = 1'b1;
                        ret_mismatch_d = (ras_top != a_tgt);
                    end else begin
                        pc_d = a_tgt;
                    end
                end
                default: pc_d = ra;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q           <= RESET_VEC;
            epc_q          <= '0;
            ret_mismatch_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            epc_q          <= epc_d;
            ret_mismatch_q <= ret_mismatch_d;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .clr       (clr),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ra),
        .top       (ras_top),
        .count     (ras_count)
    );

    assign pc           = pc_q;
    assign epc          = epc_q;
    assign ret_mismatch = ret_mismatch_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed and random stimulus for pc_seq_unit, checked against a queue-based reference model.
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        stall = 1'b0;
    logic        exc = 1'b0;
    logic [2:0]  pc_sel = 3'd0;
    logic [31:0] inst = '0;
    logic [31:0] a = '0;
    logic [31:0] pc, ra, epc;
    logic [2:0]  ras_count;
    logic        ret_mismatch;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_epc;
    logic        m_mis;
    logic        m_valid = 1'b0;
    logic [31:0] m_ras [$];

    pc_seq_unit dut (
        .clk          (clk),
        .clr          (clr),
        .stall        (stall),
        .exc          (exc),
        .pc_sel       (pc_sel),
        .inst         (inst),
        .a            (a),
        .pc           (pc),
        .ra           (ra),
        .epc          (epc),
        .ras_count    (ras_count),
        .ret_mismatch (ret_mismatch)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input logic c, input logic s, input logic e,
                             input logic [2:0] sel, input logic [31:0] ins, input logic [31:0] aa);
        logic [31:0] a_al;
        logic [31:0] popped;
        a_al = aa & ~32'h3;
        m_mis = 1'b0;
        if (c) begin
            m_pc = 32'h0; m_epc = 32'h0; m_ras.delete(); m_valid = 1'b1;
        end else if (e) begin
            m_epc = m_pc; m_pc = 32'h8000_0180;
        end else if (!s) begin
            case (sel)
                3'd1: m_pc = m_pc + 32'($signed(ins[15:0])) * 4;
                3'd2: m_pc = (m_pc & 32'hF000_0000) | (32'(ins[25:0]) * 4);
                3'd3: m_pc = a_al;
                3'd4: begin
                    m_ras.push_back(m_pc + 4);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                    m_pc = (m_pc & 32'hF000_0000) | (32'(ins[25:0]) * 4);
                end
                3'd5: begin
                    if (m_ras.size() > 0) begin
                        popped = m_ras.pop_back();
                        m_mis  = (popped != a_al);
                        m_pc   = popped;
                    end else begin
                        m_pc = a_al;
                    end
                end
                default: m_pc = m_pc + 4;
            endcase
        end
    endtask

    task automatic applyStimulus(input string tag, input logic c, input logic s, input logic e,
                                 input logic [2:0] sel, input logic [31:0] ins, input logic [31:0] aa);
        @(negedge clk);
        clr = c; stall = s; exc = e; pc_sel = sel; inst = ins; a = aa;
        if (m_valid) checkOutput({tag, ".ra"}, ra, m_pc + 32'd4);
        @(posedge clk);
        modelStep(c, s, e, sel, ins, aa);
        #1;
        checkOutput({tag, ".pc"}, pc, m_pc);
        checkOutput({tag, ".epc"}, epc, m_epc);
        checkOutput({tag, ".cnt"}, 32'(ras_count), 32'(m_ras.size()));
        checkOutput({tag, ".mis"}, 32'(ret_mismatch), 32'(m_mis));
    endtask

    initial begin
        logic [31:0] ra_val;
        logic        c, s, e;

        applyStimulus("rst0", 1, 0, 0, 3'd0, 0, 0);
        applyStimulus("rst1", 1, 0, 0, 3'd0, 0, 0);
        checkOutput("rst_pc", pc, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus("seq", 0, 0, 0, 3'd0, 0, 0);
        checkOutput("seq_pc", pc, 32'hC);

        applyStimulus("jr100", 0, 0, 0, 3'd3, 0, 32'h100);
        applyStimulus("brback", 0, 0, 0, 3'd1, 32'h0000_FFFE, 0);
        checkOutput("brback_pc", pc, 32'hF8);
        applyStimulus("brfwd", 0, 0, 0, 3'd1, 32'h0000_0003, 0);
        checkOutput("brfwd_pc", pc, 32'h104);

        applyStimulus("jrset", 0, 0, 0, 3'd3, 0, 32'h1000_0040);
        applyStimulus("j", 0, 0, 0, 3'd2, 32'h0000_0010, 0);
        checkOutput("j_pc", pc, 32'h1000_0040);
        applyStimulus("jr", 0, 0, 0, 3'd3, 0, 32'h0000_2003);
        checkOutput("jr_pc", pc, 32'h2000);

        applyStimulus("jr0", 0, 0, 0, 3'd3, 0, 32'h0);
        for (int k = 0; k < 5; k++)
            applyStimulus("call", 0, 0, 0, 3'd4, (k < 4) ? 32'((k + 1) * 32'h40) : 32'h0, 0);
        checkOutput("call_sat", 32'(ras_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            ra_val = 32'h404 - 32'(k) * 32'h100;
            applyStimulus("ret", 0, 0, 0, 3'd5, 0, ra_val);
            checkOutput("ret_pc", pc, ra_val);
        end
        applyStimulus("ret_empty", 0, 0, 0, 3'd5, 0, 32'h5000);
        checkOutput("ret_empty_pc", pc, 32'h5000);

        applyStimulus("jr40", 0, 0, 0, 3'd3, 0, 32'h40);
        applyStimulus("call40", 0, 0, 0, 3'd4, 0, 0);
        applyStimulus("retmis", 0, 0, 0, 3'd5, 0, 32'h80);
        checkOutput("retmis_pc", pc, 32'h44);
        checkOutput("retmis_pulse", 32'(ret_mismatch), 32'd1);
        applyStimulus("mis_clear", 0, 0, 0, 3'd0, 0, 0);
        checkOutput("mis_clear_pulse", 32'(ret_mismatch), 32'd0);

        applyStimulus("jr20", 0, 0, 0, 3'd3, 0, 32'h20);
        applyStimulus("call_s", 0, 0, 0, 3'd4, 32'h8, 0);
        applyStimulus("jr20b", 0, 0, 0, 3'd3, 0, 32'h20);
        applyStimulus("stall", 0, 1, 0, 3'd2, 32'h3FF, 0);
        checkOutput("stall_pc", pc, 32'h20);
        checkOutput("stall_cnt", 32'(ras_count), 32'd1);
        applyStimulus("exc", 0, 1, 1, 3'd2, 0, 0);
        checkOutput("exc_pc", pc, 32'h8000_0180);
        checkOutput("exc_epc", epc, 32'h20);
        applyStimulus("clrexc", 1, 0, 1, 3'd0, 0, 0);
        checkOutput("clrexc_pc", pc, 32'h0);
        checkOutput("clrexc_epc", epc, 32'h0);

        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 7) == 0);
            ra_val = $urandom;
            if (m_ras.size() > 0 && $urandom_range(0, 1) == 1)
                ra_val = m_ras[$] | 32'($urandom_range(0, 3));
            applyStimulus("rand", c, s, e, 3'($urandom_range(0, 7)), $urandom, ra_val);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
